rom_port_arbiter: RTL and testbench

- Shares the single genrom read port between the CPU instruction-fetch requester (f_*) and the data-load requester (d_*).
- Arbitrates between the two requesters round-robin and sequences each ROM access over a fixed latency.
- Configures the ROM bound window per requester: code window for fetch, data window for loads.
- Returns registered data/error with a one-cycle ack pulse; sits between cpu and genrom.

---
 rtl/rom_port_arbiter.sv | 169 ++++++++++++++++
 tb/tb_rom_port_arbiter.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/rom_port_arbiter.sv
// Round-robin arbiter sharing one genrom read port between instruction fetch and data load.
// Each access runs IDLE -> WAIT (LATENCY cycles) -> RESP (one-cycle ack) -> IDLE.
module rom_port_arbiter #(
  parameter int unsigned AW      = 4,
  parameter int unsigned EXTRA   = 4,
  parameter int unsigned LATENCY = 1
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  // Fetch requester
  input  logic                      f_req_i,
  input  logic [AW:0]               f_addr_i,
  input  logic [EXTRA-1:0]          f_extra_i,
  output logic                      f_ack_o,
  output logic [(2**EXTRA)*8-1:0]   f_data_o,
  output logic                      f_error_o,
  // Data requester
  input  logic                      d_req_i,
  input  logic [AW:0]               d_addr_i,
  input  logic [EXTRA-1:0]          d_extra_i,
  output logic                      d_ack_o,
  output logic [(2**EXTRA)*8-1:0]   d_data_o,
  output logic                      d_error_o,
  // Bound windows
  input  logic [AW:0]               code_lower_i,
  input  logic [AW:0]               code_upper_i,
  input  logic [AW:0]               data_lower_i,
  input  logic [AW:0]               data_upper_i,
  // genrom port
  output logic [AW:0]               mem_addr_o,
  output logic [EXTRA-1:0]          mem_extra_o,
  output logic [AW:0]               mem_lower_bound_o,
  output logic [AW:0]               mem_upper_bound_o,
  input  logic [(2**EXTRA)*8-1:0]   mem_data_i,
  input  logic                      mem_error_i,
  output logic                      busy_o
);

  localparam int unsigned DW     = (2**EXTRA) * 8;
  localparam logic [2:0]  LatCnt = 3'(LATENCY);
  localparam logic        OwnFetch = 1'b0;
  localparam logic        OwnData  = 1'b1;

  typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

  state_e            state_q, state_d;
  logic [2:0]        cnt_q, cnt_d;
  logic              owner_q, owner_d;
  logic              last_q, last_d;
  logic              pick;
  logic [AW:0]       mem_addr_q, mem_addr_d;
  logic [EXTRA-1:0]  mem_extra_q, mem_extra_d;
  logic [AW:0]       mem_lower_q, mem_lower_d;
  logic [AW:0]       mem_upper_q, mem_upper_d;
  logic              f_ack_q, f_ack_d;
  logic              d_ack_q, d_ack_d;
  logic [DW-1:0]     f_data_q, f_data_d;
  logic [DW-1:0]     d_data_q, d_data_d;
  logic              f_error_q, f_error_d;
  logic              d_error_q, d_error_d;

  // On a tie the requester that did not win last time gets the port.
  assign pick = (f_req_i && d_req_i) ? ~last_q : d_req_i;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    owner_d     = owner_q;
    last_d      = last_q;
    mem_addr_d  = mem_addr_q;
    mem_extra_d = mem_extra_q;
    mem_lower_d = mem_lower_q;
    mem_upper_d = mem_upper_q;
    f_ack_d     = 1'b0;
    d_ack_d     = 1'b0;
    f_data_d    = f_data_q;
    d_data_d    = d_data_q;
    f_error_d   = f_error_q;
    d_error_d   = d_error_q;

    case (state_q)
      StIdle: begin
        if (f_req_i || d_req_i) begin
          owner_d = pick;
          last_d  = pick;
          cnt_d   = LatCnt;
          state_d = StWait;
          if (pick == OwnData) begin
            mem_addr_d  = d_addr_i;
            mem_extra_d = d_extra_i;
            mem_lower_d = data_lower_i;
            mem_upper_d = data_upper_i;
          end else begin
            mem_addr_d  = f_addr_i;
            mem_extra_d = f_extra_i;
            mem_lower_d = code_lower_i;
            mem_upper_d = code_upper_i;
          end
        end
      end
      StWait: begin
        if (cnt_q <= 3'd1) begin
          state_d = StResp;
          if (owner_q == OwnData) begin
            d_ack_d   = 1'b1;
            d_data_d  = mem_data_i;
            d_error_d = mem_error_i;
          end else begin
            f_ack_d   = 1'b1;
            f_data_d  = mem_data_i;
            f_error_d = mem_error_i;
          end
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      // The ack-clear edge never accepts a new request.
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      owner_q     <= OwnFetch;
      last_q      <= OwnData;
      mem_addr_q  <= '0;
      mem_extra_q <= '0;
      mem_lower_q <= '0;
      mem_upper_q <= '0;
      f_ack_q     <= 1'b0;
      d_ack_q     <= 1'b0;
      f_data_q    <= '0;
      d_data_q    <= '0;
      f_error_q   <= 1'b0;
      d_error_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      owner_q     <= owner_d;
      last_q      <= last_d;
      mem_addr_q  <= mem_addr_d;
      mem_extra_q <= mem_extra_d;
      mem_lower_q <= mem_lower_d;
      mem_upper_q <= mem_upper_d;
      f_ack_q     <= f_ack_d;
      d_ack_q     <= d_ack_d;
      f_data_q    <= f_data_d;
      d_data_q    <= d_data_d;
      f_error_q   <= f_error_d;
      d_error_q   <= d_error_d;
    end
  end

  assign f_ack_o           = f_ack_q;
  assign d_ack_o           = d_ack_q;
  assign f_data_o          = f_data_q;
  assign d_data_o          = d_data_q;
  assign f_error_o         = f_error_q;
  assign d_error_o         = d_error_q;
  assign mem_addr_o        = mem_addr_q;
  assign mem_extra_o       = mem_extra_q;
  assign mem_lower_bound_o = mem_lower_q;
  assign mem_upper_bound_o = mem_upper_q;
  assign busy_o            = (state_q != StIdle);

endmodule

// File: tb/tb_rom_port_arbiter.sv
// Directed bench for rom_port_arbiter with a behavioural genrom: byte[a] = 8'h42 + a,
// error when the access leaves the lower..upper window.
module tb_rom_port_arbiter;

  localparam int unsigned AW    = 4;
  localparam int unsigned EXTRA = 4;
  localparam int unsigned DW    = (2**EXTRA) * 8;

  logic              clk;
  logic              rst_n;
  logic              f_req, d_req;
  logic [AW:0]       f_addr, d_addr;
  logic [EXTRA-1:0]  f_extra, d_extra;
  logic              f_ack, d_ack;
  logic [DW-1:0]     f_data, d_data;
  logic              f_error, d_error;
  logic [AW:0]       code_lower, code_upper, data_lower, data_upper;
  logic [AW:0]       mem_addr, mem_lower_bound, mem_upper_bound;
  logic [EXTRA-1:0]  mem_extra;
  logic [DW-1:0]     mem_data;
  logic              mem_error;
  logic              busy;

  int tests_run = 0;
  int tests_failed = 0;

  rom_port_arbiter #(.AW(AW), .EXTRA(EXTRA), .LATENCY(1)) dut (
    .clk_i             (clk),
    .rst_ni            (rst_n),
    .f_req_i           (f_req),
    .f_addr_i          (f_addr),
    .f_extra_i         (f_extra),
    .f_ack_o           (f_ack),
    .f_data_o          (f_data),
    .f_error_o         (f_error),
    .d_req_i           (d_req),
    .d_addr_i          (d_addr),
    .d_extra_i         (d_extra),
    .d_ack_o           (d_ack),
    .d_data_o          (d_data),
    .d_error_o         (d_error),
    .code_lower_i      (code_lower),
    .code_upper_i      (code_upper),
    .data_lower_i      (data_lower),
    .data_upper_i      (data_upper),
    .mem_addr_o        (mem_addr),
    .mem_extra_o       (mem_extra),
    .mem_lower_bound_o (mem_lower_bound),
    .mem_upper_bound_o (mem_upper_bound),
    .mem_data_i        (mem_data),
    .mem_error_i       (mem_error),
    .busy_o            (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural ROM: output valid one edge after mem_* are registered.
  always_comb begin
    mem_data = '0;
    for (int i = 0; i < 16; i++) begin
      if (i <= int'(mem_extra)) mem_data[i*8 +: 8] = 8'h42 + 8'(mem_addr) + 8'(i);
    end
    mem_error = (int'(mem_addr) < int'(mem_lower_bound)) ||
                (int'(mem_addr) + int'(mem_extra) > int'(mem_upper_bound));
  end

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Counts falling edges until the chosen side acks (bounded); notes any ack from the other side.
  task automatic wait_ack(input bit data_side, output int cycles, output bit other_seen);
    cycles = 0;
    other_seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      cycles++;
      if (data_side ? f_ack : d_ack) other_seen = 1'b1;
      if (data_side ? d_ack : f_ack) return;
    end
    cycles = 99;
  endtask

  int     cyc;
  bit     other;
  int     n_acks;
  bit     who   [3];
  int     when  [3];
  logic [AW:0] low [3];
  logic [DW-1:0] saved_data;
  int     busy_cnt, ack_cnt;

  initial begin
    rst_n = 1'b0;
    f_req = 1'b1; d_req = 1'b0;
    f_addr = 5'd3; f_extra = '0; d_addr = '0; d_extra = '0;
    code_lower = 5'd0; code_upper = 5'h1F;
    data_lower = 5'd0; data_upper = 5'd7;

    // Reset held with a pending fetch request
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_eq("rst_busy", busy, 0);
      check_eq("rst_f_ack", f_ack, 0);
      check_eq("rst_mem_addr", mem_addr, 0);
      check_eq("rst_f_data", f_data, 0);
    end
    f_req = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);

    // Single fetch at address 3
    f_req = 1'b1;
    wait_ack(1'b0, cyc, other);
    f_req = 1'b0;
    check_eq("fetch_latency", cyc, 2);
    check_eq("fetch_data", f_data, 128'h45);
    check_eq("fetch_error", f_error, 0);
    check_eq("fetch_no_d_ack", other, 0);
    @(negedge clk);
    check_eq("fetch_ack_pulse", f_ack, 0);
    check_eq("fetch_idle", busy, 0);

    // Both requesting from reset: F, D, F with acks 3 cycles apart
    rst_n = 1'b0;
    @(negedge clk);
    f_addr = 5'd2; f_extra = 4'd0;
    d_addr = 5'd5; d_extra = 4'd1;
    data_lower = 5'd1; data_upper = 5'd7;
    f_req = 1'b1; d_req = 1'b1;
    rst_n = 1'b1;
    n_acks = 0;
    for (int i = 1; i <= 15 && n_acks < 3; i++) begin
      @(negedge clk);
      if (f_ack || d_ack) begin
        who[n_acks]  = d_ack;
        when[n_acks] = i;
        low[n_acks]  = mem_lower_bound;
        n_acks++;
      end
    end
    f_req = 1'b0; d_req = 1'b0;
    check_eq("rr_ack_count", n_acks, 3);
    check_eq("rr_first_f", who[0], 0);
    check_eq("rr_second_d", who[1], 1);
    check_eq("rr_third_f", who[2], 0);
    check_eq("rr_first_time", when[0], 2);
    check_eq("rr_spacing_1", when[1] - when[0], 3);
    check_eq("rr_spacing_2", when[2] - when[1], 3);
    check_eq("rr_low_f", low[0], 5'd0);
    check_eq("rr_low_d", low[1], 5'd1);
    check_eq("rr_low_f2", low[2], 5'd0);
    check_eq("rr_f_data", f_data, 128'h44);
    check_eq("rr_d_data", d_data, 128'h4847);
    check_eq("rr_d_error", d_error, 0);
    @(negedge clk);

    // Data load outside its window, then fetch at the same address inside the code window
    d_addr = 5'd9; d_extra = 4'd0;
    data_lower = 5'd0; data_upper = 5'd7;
    d_req = 1'b1;
    wait_ack(1'b1, cyc, other);
    d_req = 1'b0;
    check_eq("bound_d_latency", cyc, 2);
    check_eq("bound_d_error", d_error, 1);
    saved_data = d_data;
    @(negedge clk);
    f_addr = 5'd9; f_extra = 4'd0;
    f_req = 1'b1;
    wait_ack(1'b0, cyc, other);
    f_req = 1'b0;
    check_eq("bound_f_latency", cyc, 2);
    check_eq("bound_f_error", f_error, 0);
    check_eq("bound_f_data", f_data, 128'h4B);
    check_eq("bound_d_err_held", d_error, 1);
    check_eq("bound_d_data_held", d_data, saved_data);
    @(negedge clk);

    // Request withdrawn right after the grant still completes once
    d_addr = 5'd4; d_extra = 4'd0;
    d_req = 1'b1;
    @(negedge clk);
    d_req = 1'b0;
    d_addr = 5'd0;
    wait_ack(1'b1, cyc, other);
    check_eq("wd_latency", cyc, 1);
    check_eq("wd_data", d_data, 128'h46);
    busy_cnt = 0; ack_cnt = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (busy) busy_cnt++;
      if (f_ack || d_ack) ack_cnt++;
    end
    check_eq("wd_no_second_busy", busy_cnt, 0);
    check_eq("wd_no_second_ack", ack_cnt, 0);

    // Reset during WAIT abandons the access
    f_addr = 5'd3;
    f_req = 1'b1;
    @(negedge clk);
    check_eq("rw_busy_wait", busy, 1);
    rst_n = 1'b0;
    f_req = 1'b0;
    #1;
    check_eq("rw_busy_async", busy, 0);
    check_eq("rw_ack_async", f_ack, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    busy_cnt = 0; ack_cnt = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (busy) busy_cnt++;
      if (f_ack || d_ack) ack_cnt++;
    end
    check_eq("rw_no_ack", ack_cnt, 0);
    check_eq("rw_no_busy", busy_cnt, 0);
    check_eq("rw_f_data_clr", f_data, 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
